// File: rtl/hdmi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_pkg
// Description : Shared definitions for the HDMI video timing generator.
//               Encoder mode codes, default 640x480@60 timing, FSM state
//               type and the colour-bar lookup.
// Revision    : 1.0 - initial release
// ============================================================================
package hdmi_pkg;

    // TMDS encoder mode codes
    localparam logic [1:0] STATE_CTRL  = 2'd0;
    localparam logic [1:0] STATE_VIDEO = 2'd2;

    // Default 640x480 timing
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef enum logic [1:0] {
        FSM_IDLE   = 2'd0,
        FSM_ACTIVE = 2'd1,
        FSM_DRAIN  = 2'd2
    } fsm_t;

    // Colour bars left to right, packed as {red, green, blue}
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF; // white
            3'd1:    c = 24'hFFFF00; // yellow
            3'd2:    c = 24'h00FFFF; // cyan
            3'd3:    c = 24'h00FF00; // green
            3'd4:    c = 24'hFF00FF; // magenta
            3'd5:    c = 24'hFF0000; // red
            3'd6:    c = 24'h0000FF; // blue
            default: c = 24'h000000; // black
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hdmi_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_delay_line
// Description : Fixed-depth shift register with a configurable reset value.
//               Used to hold the encoder control stream back until the RAM
//               data for the same pixel arrives.
// Ports       : clk, rst (async, active-high), i_din -> o_dout (DEPTH cycles)
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_delay_line #(
    parameter int              WIDTH   = 8,
    parameter int              DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    logic [WIDTH-1:0] r_sr [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_sr[i] <= RST_VAL;
        end else begin
            r_sr[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
        end
    end

    assign o_dout = r_sr[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/hdmi_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_timing_gen
// Description : Parametrised video timing and frame-buffer fetch generator.
//               Counters -> registered RAM address -> RAM (RD_LAT) -> output
//               register; the control stream is delayed to match.
// Ports       : clk_low/reset        pixel clock, async active-high reset
//               run                  start / keep generating frames
//               ram_addr/ram_rd_en   frame-buffer read request
//               ram_red/green/blue   RAM data, RD_LAT cycles after ram_addr
//               state/ctl            encoder mode and {vsync,hsync}
//               pix_red/green/blue   pixel data aligned with state
//               frame_start/busy     frame pulse and in-frame flag
//               test_mode            colour-bar select (optional)
// Options     : HDMI_TIMING_TEST_PATTERN_EN adds the colour-bar generator.
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_timing_gen
    import hdmi_pkg::*;
#(
    parameter int                H_ACTIVE    = DEF_H_ACTIVE,
    parameter int                H_FP        = DEF_H_FP,
    parameter int                H_SYNC      = DEF_H_SYNC,
    parameter int                H_BP        = DEF_H_BP,
    parameter int                V_ACTIVE    = DEF_V_ACTIVE,
    parameter int                V_FP        = DEF_V_FP,
    parameter int                V_SYNC      = DEF_V_SYNC,
    parameter int                V_BP        = DEF_V_BP,
    parameter bit                HSYNC_POL   = 1'b1,
    parameter bit                VSYNC_POL   = 1'b1,
    parameter int                ADDR_W      = 26,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                LINE_STRIDE = DEF_H_ACTIVE,
    parameter int                RD_LAT      = 1
) (
    input  logic              clk_low,
    input  logic              reset,
    input  logic              run,
`ifdef HDMI_TIMING_TEST_PATTERN_EN
    input  logic              test_mode,
`endif
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_en,
    input  logic [7:0]        ram_red,
    input  logic [7:0]        ram_green,
    input  logic [7:0]        ram_blue,
    output logic [1:0]        state,
    output logic [1:0]        ctl,
    output logic [7:0]        pix_red,
    output logic [7:0]        pix_green,
    output logic [7:0]        pix_blue,
    output logic              frame_start,
    output logic              busy
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W     = $clog2(H_TOTAL);
    localparam int VC_W     = $clog2(V_TOTAL);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [ADDR_W-1:0] C_STRIDE   = ADDR_W'(LINE_STRIDE);
    localparam logic [1:0]        C_CTL_IDLE = {~VSYNC_POL, ~HSYNC_POL};

`ifdef HDMI_TIMING_TEST_PATTERN_EN
    localparam int C_BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam int BP_W    = $clog2(C_BAR_W + 1);
    localparam int DL_W    = 9;
    localparam logic [DL_W-1:0] C_DL_RST = {STATE_CTRL, C_CTL_IDLE, 1'b0, 4'b0};
`else
    localparam int DL_W    = 5;
    localparam logic [DL_W-1:0] C_DL_RST = {STATE_CTRL, C_CTL_IDLE, 1'b0};
`endif

    fsm_t              r_fsm;
    logic [HC_W-1:0]   r_hc;
    logic [VC_W-1:0]   r_vc;
    logic [ADDR_W-1:0] r_line_start;

    logic [31:0] w_hc32, w_vc32;
    logic        w_running, w_hc_last, w_frame_end;
    logic        w_active, w_fetch, w_hs, w_vs, w_fs;
    logic [1:0]  w_state, w_ctl;
    logic [DL_W-1:0] w_dl_in, w_dl_out;
    logic [1:0]  w_dl_state, w_dl_ctl;
    logic        w_dl_fs;

    assign w_hc32      = 32'(r_hc);
    assign w_vc32      = 32'(r_vc);
    assign w_running   = (r_fsm != FSM_IDLE);
    assign w_hc_last   = (w_hc32 == H_TOTAL - 1);
    assign w_frame_end = w_hc_last && (w_vc32 == V_TOTAL - 1);

    // ------------------------------------------------------------------
    // Run/stop control; busy is registered alongside the state
    // ------------------------------------------------------------------
    always_ff @(posedge clk_low or posedge reset) begin
        if (reset) begin
            r_fsm <= FSM_IDLE;
            busy  <= 1'b0;
        end else begin
            case (r_fsm)
                FSM_IDLE: begin
                    if (run) begin
                        r_fsm <= FSM_ACTIVE;
                        busy  <= 1'b1;
                    end
                end
                FSM_ACTIVE: begin
                    if (!run) begin
                        // Stopping on the very last pixel needs no drain
                        if (w_frame_end) begin
                            r_fsm <= FSM_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            r_fsm <= FSM_DRAIN;
                        end
                    end
                end
                FSM_DRAIN: begin
                    if (run) begin
                        r_fsm <= FSM_ACTIVE;
                    end else if (w_frame_end) begin
                        r_fsm <= FSM_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    r_fsm <= FSM_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Raster counters and line-start address
    // ------------------------------------------------------------------
    always_ff @(posedge clk_low or posedge reset) begin
        if (reset) begin
            r_hc         <= '0;
            r_vc         <= '0;
            r_line_start <= BASE_ADDR;
        end else if (!w_running) begin
            r_hc         <= '0;
            r_vc         <= '0;
            r_line_start <= BASE_ADDR;
        end else if (w_hc_last) begin
            r_hc <= '0;
            if (w_frame_end) begin
                r_vc         <= '0;
                r_line_start <= BASE_ADDR;
            end else begin
                // Also steps through blanking lines; harmless, reloaded at vc 0
                r_vc         <= r_vc + VC_W'(1);
                r_line_start <= r_line_start + C_STRIDE;
            end
        end else begin
            r_hc <= r_hc + HC_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-pixel control decode from the counters
    // ------------------------------------------------------------------
    assign w_active = w_running && (w_hc32 < H_ACTIVE) && (w_vc32 < V_ACTIVE);
    assign w_hs     = w_running && (w_hc32 >= HS_START) && (w_hc32 < HS_END);
    assign w_vs     = w_running && (w_vc32 >= VS_START) && (w_vc32 < VS_END);
    assign w_fs     = w_running && (r_hc == '0) && (r_vc == '0);
    assign w_state  = w_active ? STATE_VIDEO : STATE_CTRL;
    assign w_ctl    = {w_vs ^ ~VSYNC_POL, w_hs ^ ~HSYNC_POL};

`ifdef HDMI_TIMING_TEST_PATTERN_EN
    logic            r_tp_mode;
    logic [BP_W-1:0] r_bar_px;
    logic [2:0]      r_bar;
    logic            w_dl_tp;
    logic [2:0]      w_dl_bar;

    // Mode is only allowed to change between frames
    always_ff @(posedge clk_low or posedge reset) begin
        if (reset) begin
            r_tp_mode <= 1'b0;
        end else if (!w_running || w_frame_end) begin
            r_tp_mode <= test_mode;
        end
    end

    // Bar index tracks hc without a divider
    always_ff @(posedge clk_low or posedge reset) begin
        if (reset) begin
            r_bar_px <= '0;
            r_bar    <= 3'd0;
        end else if (!w_running || w_hc_last) begin
            r_bar_px <= '0;
            r_bar    <= 3'd0;
        end else if (w_hc32 < H_ACTIVE) begin
            if (32'(r_bar_px) == C_BAR_W - 1) begin
                r_bar_px <= '0;
                if (r_bar != 3'd7) r_bar <= r_bar + 3'd1;
            end else begin
                r_bar_px <= r_bar_px + BP_W'(1);
            end
        end
    end

    assign w_fetch = w_active && !r_tp_mode;
    assign w_dl_in = {w_state, w_ctl, w_fs, r_tp_mode, r_bar};
    assign {w_dl_state, w_dl_ctl, w_dl_fs, w_dl_tp, w_dl_bar} = w_dl_out;
`else
    assign w_fetch = w_active;
    assign w_dl_in = {w_state, w_ctl, w_fs};
    assign {w_dl_state, w_dl_ctl, w_dl_fs} = w_dl_out;
`endif

    // ------------------------------------------------------------------
    // RAM request, one cycle behind the counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_low or posedge reset) begin
        if (reset) begin
            ram_addr  <= BASE_ADDR;
            ram_rd_en <= 1'b0;
        end else begin
            ram_rd_en <= w_fetch;
            if (w_fetch) ram_addr <= r_line_start + ADDR_W'(r_hc);
        end
    end

    // Address register stage plus RD_LAT RAM cycles
    hdmi_delay_line #(
        .WIDTH   (DL_W),
        .DEPTH   (RD_LAT + 1),
        .RST_VAL (C_DL_RST)
    ) u_delay (
        .clk    (clk_low),
        .rst    (reset),
        .i_din  (w_dl_in),
        .o_dout (w_dl_out)
    );

    // ------------------------------------------------------------------
    // Output register: control and pixel data for the same pixel
    // ------------------------------------------------------------------
    always_ff @(posedge clk_low or posedge reset) begin
        if (reset) begin
            state       <= STATE_CTRL;
            ctl         <= C_CTL_IDLE;
            frame_start <= 1'b0;
            {pix_red, pix_green, pix_blue} <= 24'h0;
        end else begin
            state       <= w_dl_state;
            ctl         <= w_dl_ctl;
            frame_start <= w_dl_fs;
            if (w_dl_state == STATE_VIDEO) begin
`ifdef HDMI_TIMING_TEST_PATTERN_EN
                if (w_dl_tp)
                    {pix_red, pix_green, pix_blue} <= bar_colour(w_dl_bar);
                else
                    {pix_red, pix_green, pix_blue} <= {ram_red, ram_green, ram_blue};
`else
                {pix_red, pix_green, pix_blue} <= {ram_red, ram_green, ram_blue};
`endif
            end else begin
                {pix_red, pix_green, pix_blue} <= 24'h0;
            end
        end
    end

endmodule
`default_nettype wire
